depth_test_sequencer: RTL and testbench



---
 rtl/depth_test_sequencer_if.sv | 57 +++++
 rtl/depth_test_sequencer.sv | 125 ++++++++++++
 tb/tb_depth_test_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/depth_test_sequencer_if.sv
// Bus bundle between the depth test sequencer and its neighbours: upstream
// fragment stream, depth-buffer start/done port, downstream colour-write
// stream, flush request and status. slave = sequencer side, master = the
// surrounding pipeline.
interface depth_test_sequencer_if #(
  parameter int X_RES        = 4,
  parameter int Y_RES        = 4,
  parameter int X_PIXEL_SIZE = $clog2(X_RES),
  parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
  parameter int Z_SIZE       = 8,
  parameter int COLOR_SIZE   = 16,
  parameter int CNT_SIZE     = 16
);
  // upstream fragment stream
  logic                    frag_valid_i;
  logic                    frag_ready_o;
  logic [X_PIXEL_SIZE-1:0] frag_x_i;
  logic [Y_PIXEL_SIZE-1:0] frag_y_i;
  logic [Z_SIZE-1:0]       frag_z_i;
  logic [COLOR_SIZE-1:0]   frag_color_i;
  logic                    flush_req_i;
  // depth-buffer unit port
  logic                    zt_start_o;
  logic                    zt_flush_o;
  logic [X_PIXEL_SIZE-1:0] zt_pixel_x_o;
  logic [Y_PIXEL_SIZE-1:0] zt_pixel_y_o;
  logic [Z_SIZE-1:0]       zt_pixel_z_o;
  logic                    zt_done_i;
  logic                    zt_depth_pass_i;
  // downstream passed-fragment stream
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [X_PIXEL_SIZE-1:0] out_x_o;
  logic [Y_PIXEL_SIZE-1:0] out_y_o;
  logic [COLOR_SIZE-1:0]   out_color_o;
  // status
  logic [CNT_SIZE-1:0]     pass_count_o;
  logic [CNT_SIZE-1:0]     kill_count_o;
  logic                    flush_busy_o;
  logic                    idle_o;

  modport slave (
    input  frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_color_i, flush_req_i,
    input  zt_done_i, zt_depth_pass_i, out_ready_i,
    output frag_ready_o, zt_start_o, zt_flush_o, zt_pixel_x_o, zt_pixel_y_o, zt_pixel_z_o,
    output out_valid_o, out_x_o, out_y_o, out_color_o,
    output pass_count_o, kill_count_o, flush_busy_o, idle_o
  );

  modport master (
    output frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_color_i, flush_req_i,
    output zt_done_i, zt_depth_pass_i, out_ready_i,
    input  frag_ready_o, zt_start_o, zt_flush_o, zt_pixel_x_o, zt_pixel_y_o, zt_pixel_z_o,
    input  out_valid_o, out_x_o, out_y_o, out_color_o,
    input  pass_count_o, kill_count_o, flush_busy_o, idle_o
  );
endinterface

// File: rtl/depth_test_sequencer.sv
// Issues one depth test at a time to the depth-buffer unit, forwards passing
// fragments downstream, drops and counts failing ones, and slots depth-buffer
// flushes in between fragments (flush wins over a waiting fragment).
module depth_test_sequencer #(
  parameter int X_RES        = 4,
  parameter int Y_RES        = 4,
  parameter int X_PIXEL_SIZE = $clog2(X_RES),
  parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
  parameter int Z_SIZE       = 8,
  parameter int COLOR_SIZE   = 16,
  parameter int CNT_SIZE     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  depth_test_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, EMIT, FLUSH_ISSUE, FLUSH_WAIT
  } state_t;

  state_t                  state;
  logic                    pend;
  logic [X_PIXEL_SIZE-1:0] x_q;
  logic [Y_PIXEL_SIZE-1:0] y_q;
  logic [Z_SIZE-1:0]       z_q;
  logic [COLOR_SIZE-1:0]   color_q;
  logic                    start_q, flush_q, out_valid_q, busy_q, idle_q;
  logic [CNT_SIZE-1:0]     pass_cnt, kill_cnt;
  logic                    busy_nxt, idle_nxt;

  // Only combinational output; held low during reset so nothing is taken.
  assign bus.frag_ready_o = (state == IDLE) && !pend && !rst_i;

  // Busy next cycle if a flush is (or becomes) pending or the flush is still
  // in flight; a pending flag always leads into FLUSH_ISSUE from IDLE.
  assign busy_nxt = bus.flush_req_i || pend || (state == FLUSH_ISSUE) ||
                    ((state == FLUSH_WAIT) && !bus.zt_done_i);

  // Idle next cycle when the FSM lands in (or stays in) IDLE with nothing pending.
  assign idle_nxt = !bus.flush_req_i && !pend &&
                    (((state == IDLE) && !bus.frag_valid_i) ||
                     ((state == WAIT) && bus.zt_done_i && !bus.zt_depth_pass_i) ||
                     ((state == EMIT) && bus.out_ready_i) ||
                     ((state == FLUSH_WAIT) && bus.zt_done_i));

  // Sequencer FSM with registered outputs and saturating statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pend        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      color_q     <= '0;
      start_q     <= 1'b0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b1;
      pass_cnt    <= '0;
      kill_cnt    <= '0;
    end else begin
      // A new request in the same cycle as the IDLE->FLUSH_ISSUE clear survives.
      pend    <= bus.flush_req_i || (pend && (state != IDLE));
      busy_q  <= busy_nxt;
      idle_q  <= idle_nxt;
      start_q <= 1'b0;
      flush_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            state   <= FLUSH_ISSUE;
            start_q <= 1'b1;
            flush_q <= 1'b1;
          end else if (bus.frag_valid_i) begin
            x_q     <= bus.frag_x_i;
            y_q     <= bus.frag_y_i;
            z_q     <= bus.frag_z_i;
            color_q <= bus.frag_color_i;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.zt_done_i) begin
            if (bus.zt_depth_pass_i) begin
              out_valid_q <= 1'b1;
              state       <= EMIT;
            end else begin
              if (~&kill_cnt) kill_cnt <= kill_cnt + 1'b1;
              state <= IDLE;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            if (~&pass_cnt) pass_cnt <= pass_cnt + 1'b1;
            state <= IDLE;
          end
        end
        FLUSH_ISSUE: state <= FLUSH_WAIT;
        FLUSH_WAIT: if (bus.zt_done_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.zt_start_o   = start_q;
  assign bus.zt_flush_o   = flush_q;
  assign bus.zt_pixel_x_o = x_q;
  assign bus.zt_pixel_y_o = y_q;
  assign bus.zt_pixel_z_o = z_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_x_o      = x_q;
  assign bus.out_y_o      = y_q;
  assign bus.out_color_o  = color_q;
  assign bus.pass_count_o = pass_cnt;
  assign bus.kill_count_o = kill_cnt;
  assign bus.flush_busy_o = busy_q;
  assign bus.idle_o       = idle_q;

endmodule

// File: tb/tb_depth_test_sequencer.sv
// Directed bench for depth_test_sequencer: pass, kill, backpressure, flush
// priority, double flush, reset mid-test and counter saturation (CNT_SIZE=2).
module tb_depth_test_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  depth_test_sequencer_if #(.CNT_SIZE(2)) bus ();
  depth_test_sequencer #(.CNT_SIZE(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fragment in IDLE, let it be taken, check the ISSUE cycle.
  task automatic send_frag(input int x, input int y, input int z, input int c);
    bus.frag_valid_i = 1'b1;
    bus.frag_x_i     = 2'(x);
    bus.frag_y_i     = 2'(y);
    bus.frag_z_i     = 8'(z);
    bus.frag_color_i = 16'(c);
    chk("rdy_before", 32'(bus.frag_ready_o), 1);
    tick();
    bus.frag_valid_i = 1'b0;
    chk("start", 32'(bus.zt_start_o), 1);
    chk("start_flush", 32'(bus.zt_flush_o), 0);
    chk("pix_x", 32'(bus.zt_pixel_x_o), 32'(x));
    chk("pix_y", 32'(bus.zt_pixel_y_o), 32'(y));
    chk("pix_z", 32'(bus.zt_pixel_z_o), 32'(z));
  endtask

  // Wait n cycles in WAIT (start must be gone, coords stable), then return done.
  task automatic finish_test(input logic pass, input int n, input int x, input int z);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("start_single", 32'(bus.zt_start_o), 0);
      chk("pix_x_hold", 32'(bus.zt_pixel_x_o), 32'(x));
      chk("pix_z_hold", 32'(bus.zt_pixel_z_o), 32'(z));
      chk("rdy_wait", 32'(bus.frag_ready_o), 0);
    end
    bus.zt_done_i       = 1'b1;
    bus.zt_depth_pass_i = pass;
    tick();
    bus.zt_done_i       = 1'b0;
    bus.zt_depth_pass_i = 1'b0;
  endtask

  initial begin
    bus.frag_valid_i = 0; bus.frag_x_i = 0; bus.frag_y_i = 0; bus.frag_z_i = 0;
    bus.frag_color_i = 0; bus.flush_req_i = 0; bus.zt_done_i = 0;
    bus.zt_depth_pass_i = 0; bus.out_ready_i = 0;

    // reset state
    tick(); tick();
    chk("rst_rdy", 32'(bus.frag_ready_o), 0);
    chk("rst_idle", 32'(bus.idle_o), 1);
    chk("rst_start", 32'(bus.zt_start_o), 0);
    chk("rst_oval", 32'(bus.out_valid_o), 0);
    chk("rst_busy", 32'(bus.flush_busy_o), 0);
    chk("rst_pcnt", 32'(bus.pass_count_o), 0);
    chk("rst_kcnt", 32'(bus.kill_count_o), 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(bus.frag_ready_o), 1);

    // pass path: done 4 cycles after the start pulse
    send_frag(1, 2, 5, 'hABCD);
    finish_test(1'b1, 3, 1, 5);
    chk("pass_oval", 32'(bus.out_valid_o), 1);
    chk("pass_ocol", 32'(bus.out_color_o), 'hABCD);
    chk("pass_ox", 32'(bus.out_x_o), 1);
    chk("pass_oy", 32'(bus.out_y_o), 2);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("pass_cnt1", 32'(bus.pass_count_o), 1);
    chk("pass_oval_off", 32'(bus.out_valid_o), 0);
    chk("pass_idle", 32'(bus.idle_o), 1);

    // kill path
    send_frag(1, 2, 5, 'hABCD);
    finish_test(1'b0, 3, 1, 5);
    chk("kill_oval", 32'(bus.out_valid_o), 0);
    chk("kill_cnt1", 32'(bus.kill_count_o), 1);
    chk("kill_rdy", 32'(bus.frag_ready_o), 1);
    chk("kill_pcnt", 32'(bus.pass_count_o), 1);

    // backpressure: 5 cycles with out_ready low, accepted on the 6th
    send_frag(3, 1, 9, 'h1234);
    finish_test(1'b1, 1, 3, 9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_oval", 32'(bus.out_valid_o), 1);
      chk("bp_ox", 32'(bus.out_x_o), 3);
      chk("bp_ocol", 32'(bus.out_color_o), 'h1234);
      chk("bp_rdy", 32'(bus.frag_ready_o), 0);
      tick();
    end
    chk("bp_oval6", 32'(bus.out_valid_o), 1);
    chk("bp_pcnt_hold", 32'(bus.pass_count_o), 1);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("bp_pcnt", 32'(bus.pass_count_o), 2);
    chk("bp_oval_off", 32'(bus.out_valid_o), 0);

    // flush priority: flush arrives during WAIT while a new fragment waits
    send_frag(2, 3, 7, 'h0F0F);
    tick();
    bus.flush_req_i  = 1'b1;
    bus.frag_valid_i = 1'b1;
    bus.frag_x_i = 2'd0; bus.frag_y_i = 2'd1; bus.frag_z_i = 8'd2; bus.frag_color_i = 16'h5555;
    tick();
    bus.flush_req_i = 1'b0;
    chk("fp_busy_wait", 32'(bus.flush_busy_o), 1);
    chk("fp_idle_wait", 32'(bus.idle_o), 0);
    bus.zt_done_i = 1'b1;
    tick();
    bus.zt_done_i = 1'b0;
    chk("fp_kcnt", 32'(bus.kill_count_o), 2);
    chk("fp_rdy_blocked", 32'(bus.frag_ready_o), 0);
    chk("fp_busy_idle", 32'(bus.flush_busy_o), 1);
    chk("fp_idle_pend", 32'(bus.idle_o), 0);
    tick();
    chk("fp_fstart", 32'(bus.zt_start_o), 1);
    chk("fp_fflush", 32'(bus.zt_flush_o), 1);
    chk("fp_busy_fi", 32'(bus.flush_busy_o), 1);
    tick();
    chk("fp_fstart_off", 32'(bus.zt_start_o), 0);
    chk("fp_busy_fw", 32'(bus.flush_busy_o), 1);
    bus.zt_done_i = 1'b1;
    bus.zt_depth_pass_i = 1'b1;
    tick();
    bus.zt_done_i = 1'b0;
    bus.zt_depth_pass_i = 1'b0;
    chk("fp_busy_done", 32'(bus.flush_busy_o), 0);
    chk("fp_rdy_done", 32'(bus.frag_ready_o), 1);
    chk("fp_no_emit", 32'(bus.out_valid_o), 0);
    tick();
    bus.frag_valid_i = 1'b0;
    chk("fp_start2", 32'(bus.zt_start_o), 1);
    chk("fp_flush2", 32'(bus.zt_flush_o), 0);
    chk("fp_pix_y2", 32'(bus.zt_pixel_y_o), 1);
    chk("fp_pix_z2", 32'(bus.zt_pixel_z_o), 2);
    finish_test(1'b1, 1, 0, 2);
    chk("fp_ocol", 32'(bus.out_color_o), 'h5555);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("fp_pcnt", 32'(bus.pass_count_o), 3);

    // double flush: second request coincides with IDLE->FLUSH_ISSUE
    bus.flush_req_i = 1'b1;
    tick();
    chk("df_busy", 32'(bus.flush_busy_o), 1);
    chk("df_rdy", 32'(bus.frag_ready_o), 0);
    tick();
    bus.flush_req_i = 1'b0;
    chk("df_start1", 32'(bus.zt_start_o), 1);
    chk("df_flush1", 32'(bus.zt_flush_o), 1);
    tick();
    bus.zt_done_i = 1'b1;
    tick();
    bus.zt_done_i = 1'b0;
    chk("df_busy_mid", 32'(bus.flush_busy_o), 1);
    chk("df_rdy_mid", 32'(bus.frag_ready_o), 0);
    tick();
    chk("df_start2", 32'(bus.zt_start_o), 1);
    chk("df_flush2", 32'(bus.zt_flush_o), 1);
    tick();
    bus.zt_done_i = 1'b1;
    tick();
    bus.zt_done_i = 1'b0;
    chk("df_busy_end", 32'(bus.flush_busy_o), 0);
    chk("df_idle_end", 32'(bus.idle_o), 1);

    // reset during WAIT abandons the fragment
    send_frag(1, 1, 1, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_rdy", 32'(bus.frag_ready_o), 0);
    chk("mr_start", 32'(bus.zt_start_o), 0);
    chk("mr_oval", 32'(bus.out_valid_o), 0);
    chk("mr_pix_x", 32'(bus.zt_pixel_x_o), 0);
    chk("mr_pcnt", 32'(bus.pass_count_o), 0);
    chk("mr_kcnt", 32'(bus.kill_count_o), 0);
    chk("mr_busy", 32'(bus.flush_busy_o), 0);
    chk("mr_idle", 32'(bus.idle_o), 1);
    rst = 1'b0;
    tick();
    chk("mr_no_emit", 32'(bus.out_valid_o), 0);

    // saturation: 5 kills on a 2-bit counter stop at 3
    for (int i = 0; i < 5; i++) begin
      send_frag(i % 4, 3, i + 10, i);
      finish_test(1'b0, 1, i % 4, i + 10);
    end
    chk("sat_kcnt", 32'(bus.kill_count_o), 3);
    chk("sat_pcnt", 32'(bus.pass_count_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
